// File: rtl/telemetry_frame_tx_if.sv
// Byte-wide start/busy handshake between the telemetry framer and a UART transmitter.
interface telemetry_frame_tx_if;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_busy;

  modport master (output tx_start, output tx_data, input tx_busy);
  modport slave  (input tx_start, input tx_data, output tx_busy);
endinterface

// File: rtl/telemetry_frame_tx.sv
// Periodic ASCII telemetry framer: snapshots NUM_CH channel words on each period tick and
// streams "<hdr> HHHH ... HHHH\r\n" one byte at a time into a start/busy UART transmitter.
module telemetry_frame_tx #(
  parameter int         NUM_CH        = 4,
  parameter int         CH_WIDTH      = 16,
  parameter int         PERIOD_CYCLES = 10000,
  parameter logic [7:0] HEADER_CHAR   = 8'h61
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_enable,
  input  logic [NUM_CH*CH_WIDTH-1:0] i_ch_data,
  telemetry_frame_tx_if.master       tx,
  output logic                       o_snapshot,
  output logic                       o_frame_active,
  output logic [7:0]                 o_overrun_cnt
);

  localparam int DIGITS = (CH_WIDTH + 3) / 4;
  localparam int PAD_W  = DIGITS * 4;
  localparam int CNT_W  = (PERIOD_CYCLES > 2) ? $clog2(PERIOD_CYCLES) : 1;
  localparam int CH_IW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int POS_W  = $clog2(DIGITS + 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SEND, S_HOLD, S_WAITB} state_t;
  typedef enum logic [1:0] {P_HDR, P_CH, P_CR, P_LF} part_t;

  state_t                     r_state;
  part_t                      r_part;
  logic [CNT_W-1:0]           r_cnt;
  logic [CH_IW-1:0]           r_ch;
  logic [POS_W-1:0]           r_pos;
  logic [NUM_CH*CH_WIDTH-1:0] r_snap;
  logic                       r_tx_start;
  logic [7:0]                 r_tx_data;
  logic                       r_snapshot;
  logic                       r_frame_active;
  logic [7:0]                 r_overrun;

  logic                       w_tick;
  logic [CH_WIDTH-1:0]        w_word;
  logic [PAD_W-1:0]           w_pad;
  logic [3:0]                 w_nib;
  logic [7:0]                 w_byte;

  function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
    if (nib < 4'd10) begin
      return 8'h30 + {4'h0, nib};
    end else begin
      return 8'h37 + {4'h0, nib};
    end
  endfunction

  assign w_tick = (r_cnt == CNT_W'(PERIOD_CYCLES - 1));

  // Free-running frame period counter, independent of enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Byte generator: r_pos 0 is the separating space, 1..DIGITS walk the nibbles MSB first.
  always_comb begin
    w_word = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_word = (r_ch == CH_IW'(i)) ? r_snap[i*CH_WIDTH +: CH_WIDTH] : w_word;
    end
    w_pad = PAD_W'(w_word);
    w_nib = 4'h0;
    for (int d = 0; d < DIGITS; d++) begin
      w_nib = (r_pos == POS_W'(DIGITS - d)) ? w_pad[d*4 +: 4] : w_nib;
    end
    case (r_part)
      P_HDR:   w_byte = HEADER_CHAR;
      P_CH:    w_byte = (r_pos == '0) ? 8'h20 : hex_ascii(w_nib);
      P_CR:    w_byte = 8'h0D;
      P_LF:    w_byte = 8'h0A;
      default: w_byte = 8'h00;
    endcase
  end

  // Frame sequencer; HOLD covers the cycle before the transmitter's busy flag rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_part         <= P_HDR;
      r_ch           <= '0;
      r_pos          <= '0;
      r_snap         <= '0;
      r_tx_start     <= 1'b0;
      r_tx_data      <= 8'h00;
      r_snapshot     <= 1'b0;
      r_frame_active <= 1'b0;
      r_overrun      <= 8'h00;
    end else begin
      r_tx_start <= 1'b0;
      r_snapshot <= 1'b0;
      if (w_tick && (r_state != S_IDLE) && (r_overrun != 8'hFF)) begin
        r_overrun <= r_overrun + 8'd1;
      end
      case (r_state)
        S_IDLE: begin
          if (w_tick && i_enable) begin
            r_snap         <= i_ch_data;
            r_snapshot     <= 1'b1;
            r_frame_active <= 1'b1;
            r_part         <= P_HDR;
            r_ch           <= '0;
            r_pos          <= '0;
            r_state        <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_tx_data <= w_byte;
          r_state   <= S_SEND;
        end
        S_SEND: begin
          if (!tx.tx_busy) begin
            r_tx_start <= 1'b1;
            r_state    <= S_HOLD;
          end
        end
        S_HOLD: begin
          r_state <= S_WAITB;
        end
        S_WAITB: begin
          if (!tx.tx_busy) begin
            case (r_part)
              P_HDR: begin
                r_part  <= P_CH;
                r_state <= S_LOAD;
              end
              P_CH: begin
                if (r_pos == POS_W'(DIGITS)) begin
                  r_pos <= '0;
                  if (r_ch == CH_IW'(NUM_CH - 1)) begin
                    r_part <= P_CR;
                  end else begin
                    r_ch <= r_ch + CH_IW'(1);
                  end
                end else begin
                  r_pos <= r_pos + POS_W'(1);
                end
                r_state <= S_LOAD;
              end
              P_CR: begin
                r_part  <= P_LF;
                r_state <= S_LOAD;
              end
              default: begin
                r_frame_active <= 1'b0;
                r_state        <= S_IDLE;
              end
            endcase
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign tx.tx_start    = r_tx_start;
  assign tx.tx_data     = r_tx_data;
  assign o_snapshot     = r_snapshot;
  assign o_frame_active = r_frame_active;
  assign o_overrun_cnt  = r_overrun;

endmodule

// File: tb/tb_telemetry_frame_tx.sv
// Scoreboard bench: a cycle-level tick/enable model predicts snapshots and builds each frame
// as an ASCII string; a negedge monitor pops and compares every byte the framers emit.
module tb_telemetry_frame_tx;
  localparam int P1 = 10000;
  localparam int P2 = 400;
  localparam int BUSY1 = 10;
  localparam int BUSY2 = 3;

  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en1 = 1'b0, en2 = 1'b1;
  logic [63:0] data1 = 64'h0000_FFFF_00A5_12AB;
  logic [19:0] data2 = {10'h001, 10'h3FF};
  logic        snap1, fa1, snap2, fa2;
  logic [7:0]  ovr1, ovr2;

  telemetry_frame_tx_if if1();
  telemetry_frame_tx_if if2();

  telemetry_frame_tx u_dut1 (
    .clk(clk), .rst_n(rst_n), .i_enable(en1), .i_ch_data(data1), .tx(if1),
    .o_snapshot(snap1), .o_frame_active(fa1), .o_overrun_cnt(ovr1));

  telemetry_frame_tx #(.NUM_CH(2), .CH_WIDTH(10), .PERIOD_CYCLES(P2), .HEADER_CHAR(8'h61)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .i_enable(en2), .i_ch_data(data2), .tx(if2),
    .o_snapshot(snap2), .o_frame_active(fa2), .o_overrun_cnt(ovr2));

  always #5 clk = ~clk;

  int n_checks = 0, n_pass = 0;
  bq_t exp1, exp2;
  int  m_cnt1 = 0, m_cnt2 = 0, m_ovr1 = 0, m_ovr2 = 0, m_left1 = 0, m_left2 = 0;
  bit  m_act1 = 0, m_act2 = 0, exp_snap1 = 0, exp_snap2 = 0, hold1 = 0;
  int  busy1 = 0, busy2 = 0, bytes1 = 0, done1 = 0, nsnap1 = 0, nsnap_dut1 = 0;
  logic        s_rst = 1'b0, s_en1 = 1'b0, s_en2 = 1'b0;
  logic [63:0] s_d1 = 64'h0;
  logic [19:0] s_d2 = 20'h0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    $display("FAIL %s: bound expired (t=%0t)", name, $time);
  endtask

  function automatic bq_t make_frame(input logic [511:0] data, input int nch, input int w);
    bq_t q;
    string hexs = "0123456789ABCDEF";
    logic [511:0] word;
    int nd = (w + 3) / 4;
    q.push_back(8'h61);
    for (int ch = 0; ch < nch; ch++) begin
      word = (data >> (ch * w)) & ((512'd1 << w) - 512'd1);
      q.push_back(8'h20);
      for (int d = nd - 1; d >= 0; d--) q.push_back(hexs[int'(word[4*d +: 4])]);
    end
    q.push_back(8'h0D);
    q.push_back(8'h0A);
    return q;
  endfunction

  // Inputs as the DUTs saw them at the active edge.
  always @(posedge clk) begin
    s_rst <= rst_n; s_en1 <= en1; s_en2 <= en2; s_d1 <= data1; s_d2 <= data2;
  end

  // Reference model, scoreboard monitor and transmitter busy models.
  initial begin
    bq_t nf;
    logic [7:0] e;
    if1.tx_busy = 1'b0;
    if2.tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n || !s_rst) begin
        m_cnt1 = 0; m_act1 = 0; m_ovr1 = 0; exp1.delete(); exp_snap1 = 0;
        m_cnt2 = 0; m_act2 = 0; m_ovr2 = 0; exp2.delete(); exp_snap2 = 0;
      end else begin
        exp_snap1 = 0;
        exp_snap2 = 0;
        if (m_cnt1 == P1 - 1) begin
          m_cnt1 = 0;
          if (m_act1) m_ovr1 = (m_ovr1 < 255) ? m_ovr1 + 1 : 255;
          else if (s_en1) begin
            exp_snap1 = 1; m_act1 = 1; nsnap1++;
            nf = make_frame(512'(s_d1), 4, 16);
            m_left1 = nf.size();
            foreach (nf[i]) exp1.push_back(nf[i]);
          end
        end else m_cnt1++;
        if (m_cnt2 == P2 - 1) begin
          m_cnt2 = 0;
          if (m_act2) m_ovr2 = (m_ovr2 < 255) ? m_ovr2 + 1 : 255;
          else if (s_en2) begin
            exp_snap2 = 1; m_act2 = 1;
            nf = make_frame(512'(s_d2), 2, 10);
            m_left2 = nf.size();
            foreach (nf[i]) exp2.push_back(nf[i]);
          end
        end else m_cnt2++;
      end

      if (snap1) nsnap_dut1++;
      if (snap1 || exp_snap1) check("snapshot1", snap1, exp_snap1);
      if (exp_snap1) check("frame_active1_set", fa1, 1'b1);
      if (snap2 || exp_snap2) check("snapshot2", snap2, exp_snap2);

      if (if1.tx_start) begin
        check("start_while_busy1", if1.tx_busy, 1'b0);
        if (exp1.size() == 0) fail_now("unexpected_byte1");
        else begin
          e = exp1.pop_front();
          check("byte1", if1.tx_data, e);
          bytes1++;
          m_left1--;
          if (m_left1 == 0) begin m_act1 = 0; done1++; end
        end
        busy1 = BUSY1;
      end else if (busy1 > 0) busy1--;
      if1.tx_busy = (busy1 != 0) || hold1;

      if (if2.tx_start) begin
        check("start_while_busy2", if2.tx_busy, 1'b0);
        if (exp2.size() == 0) fail_now("unexpected_byte2");
        else begin
          e = exp2.pop_front();
          check("byte2", if2.tx_data, e);
          m_left2--;
          if (m_left2 == 0) m_act2 = 0;
        end
        busy2 = BUSY2;
      end else if (busy2 > 0) busy2--;
      if2.tx_busy = (busy2 != 0);
    end
  end

  // Fresh random words for the small framer after every one of its snapshots.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_snap2) begin
        @(posedge clk);
        #2 data2 = 20'($urandom);
      end
    end
  end

  task automatic wait_snap1(input int limit);
    int k = 0;
    do begin @(negedge clk); k++; end while (!exp_snap1 && k < limit);
    if (!exp_snap1) fail_now("snap1_timeout");
  endtask

  task automatic wait_bytes1(input int target, input int limit);
    int k = 0;
    while (bytes1 < target && k < limit) begin @(negedge clk); k++; end
    if (bytes1 < target) fail_now("bytes1_timeout");
  endtask

  task automatic wait_done1(input int target, input int limit);
    int k = 0;
    while (done1 < target && k < limit) begin @(negedge clk); k++; end
    if (done1 < target) fail_now("frame1_timeout");
    repeat (20) @(negedge clk);
    check("frame_active1_idle", fa1, 1'b0);
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (25000) @(posedge clk);
    #2 en1 = 1'b1;

    // Fixed frame "a 12AB 00A5 FFFF 0000\r\n", then new words right after the capture.
    wait_snap1(6000);
    @(posedge clk);
    #2 data1 = {$urandom, $urandom};
    wait_done1(1, 2000);
    check("overrun_after_frame1", ovr1, 8'(m_ovr1));

    // Transmitter stuck busy across a tick: the frame pauses, one overrun, then resumes.
    wait_snap1(P1 + 100);
    wait_bytes1(bytes1 + 5, 500);
    @(posedge clk);
    #2 hold1 = 1'b1;
    repeat (12000) @(posedge clk);
    #2 hold1 = 1'b0;
    wait_done1(2, 2000);
    check("overrun_after_hold", ovr1, 8'(m_ovr1));
    check("overrun_is_one", ovr1, 8'd1);

    // Reset in the middle of a frame.
    data1 = {$urandom, $urandom};
    wait_snap1(P1 + 100);
    wait_bytes1(bytes1 + 5, 500);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_tx_start", if1.tx_start, 1'b0);
    check("rst_tx_data", if1.tx_data, 8'h00);
    check("rst_snapshot", snap1, 1'b0);
    check("rst_frame_active", fa1, 1'b0);
    check("rst_overrun", ovr1, 8'h00);
    @(posedge clk);
    #2 rst_n = 1'b1;
    data1 = {$urandom, $urandom};
    n = 0;
    do begin @(posedge clk); n++; #1; end while (!snap1 && n < P1 + 10);
    check("first_snap_latency", 64'(n), 64'(P1));

    // Dropping enable mid-frame lets this frame finish and blocks later ones.
    wait_bytes1(bytes1 + 8, 500);
    @(posedge clk);
    #2 en1 = 1'b0;
    wait_done1(3, 2000);
    repeat (P1 + 100) @(posedge clk);
    #1;
    check("snapshot_count", 64'(nsnap_dut1), 64'(nsnap1));
    check("final_overrun1", ovr1, 8'(m_ovr1));
    check("final_pending1", 64'(exp1.size()), 64'd0);
    check("final_overrun2", ovr2, 8'(m_ovr2));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
